fetch_sequencer: RTL and testbench

- Control FSM that runs the fetch/decode/advance cycle of the von Neumann core.
- Drives the program counter's load/inc/reset controls and owns the single shared memory port for both instruction fetches and LOAD/STORE data accesses.
- Sits between the `pc` register, unified memory and the accumulator datapath.
- Adds a memory-wait timeout with a sticky fault flag.

---
 rtl/fetch_sequencer_if.sv | 24 ++
 rtl/fetch_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Shared memory port of the von Neumann core: one request channel used for
// both instruction fetches and LOAD/STORE data accesses.
`timescale 1ns/1ps
interface fetch_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode/advance control FSM: sequences the PC, arbitrates the single
// memory port between fetches and data accesses, and traps stalled accesses.
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_in,
  output logic              pc_load,
  output logic              pc_inc,
  output logic              pc_rst,
  fetch_sequencer_if.master mem,
  input  logic [DATA_W-1:0] acc_in,
  input  logic              zero_flag,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              exec_strobe,
  output logic              halted,
  output logic              fault
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_JMP   = 4'h3;
  localparam logic [3:0] OP_BRZ   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // The counter only has to reach TIMEOUT-1: the limit cycle itself is decoded.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_PCRST,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_ADV_INC,
    S_ADV_LOAD,
    S_HALT
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              waiting;
  logic              timed_out;

  assign opcode  = ir[15:12];
  assign operand = ADDR_W'(ir[11:0]);
  assign waiting = (state == S_FETCH) || (state == S_MEM);

  // A ready in the limit cycle completes the access instead of faulting.
  assign timed_out = (TIMEOUT != 0) && waiting && !mem.mem_ready &&
                     (wait_cnt == CNT_W'(LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_PCRST;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir        <= '0;
      load_data <= '0;
      fault     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if (state == S_FETCH && mem.mem_ready) begin
        ir <= mem.mem_rdata;
      end
      if (state == S_MEM && mem.mem_ready && opcode == OP_LOAD) begin
        load_data <= mem.mem_rdata;
      end
      if (timed_out) begin
        fault <= 1'b1;
      end
      wait_cnt <= (waiting && !mem.mem_ready && !timed_out) ? wait_cnt + CNT_W'(1) : '0;
    end
  end

  always_comb begin
    next_state    = state;
    pc_in         = '0;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_rst        = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    load_valid    = 1'b0;
    exec_strobe   = 1'b0;
    halted        = 1'b0;
    unique case (state)
      S_PCRST: begin
        pc_rst     = 1'b1;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = pc_out;
        if (mem.mem_ready) begin
          next_state = S_DECODE;
        end else if (timed_out) begin
          next_state = S_HALT;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          OP_NOP:           next_state = S_ADV_INC;
          OP_LOAD, OP_STORE: next_state = S_MEM;
          OP_JMP:           next_state = S_ADV_LOAD;
          OP_BRZ:           next_state = zero_flag ? S_ADV_LOAD : S_ADV_INC;
          OP_HALT:          next_state = S_HALT;
          default:          next_state = S_EXEC;
        endcase
      end
      S_EXEC: begin
        exec_strobe = 1'b1;
        next_state  = S_ADV_INC;
      end
      S_MEM: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = operand;
        if (opcode == OP_STORE) begin
          mem.mem_we    = 1'b1;
          mem.mem_wdata = acc_in;
        end
        if (mem.mem_ready) begin
          next_state = S_ADV_INC;
        end else if (timed_out) begin
          next_state = S_HALT;
        end
      end
      S_ADV_INC: begin
        // Only a completed LOAD reaches ADV_INC with a LOAD opcode in ir.
        pc_inc     = 1'b1;
        load_valid = (opcode == OP_LOAD);
        next_state = S_FETCH;
      end
      S_ADV_LOAD: begin
        pc_load    = 1'b1;
        pc_in      = operand;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start && !fault) begin
          next_state = S_ADV_INC;
        end
      end
      default: next_state = S_PCRST;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of single-instruction vectors
// plus hand-written halt/resume, timeout and mid-access reset sequences.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] pc_out = '0;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_load, pc_inc, pc_rst;
  logic [DATA_W-1:0] acc_in = '0;
  logic              zero_flag = 1'b0;
  logic [DATA_W-1:0] ir, load_data;
  logic              load_valid, exec_strobe, halted, fault;

  int assertions = 0;
  int failures   = 0;

  fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pc_out     (pc_out),
    .pc_in      (pc_in),
    .pc_load    (pc_load),
    .pc_inc     (pc_inc),
    .pc_rst     (pc_rst),
    .mem        (mem_bus),
    .acc_in     (acc_in),
    .zero_flag  (zero_flag),
    .ir         (ir),
    .load_data  (load_data),
    .load_valid (load_valid),
    .exec_strobe(exec_strobe),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Stand-in for the external pc register driven by the sequencer controls.
  always @(posedge clk) begin
    if (pc_rst)       pc_out <= '0;
    else if (pc_load) pc_out <= pc_in;
    else if (pc_inc)  pc_out <= pc_out + 16'h0001;
  end

  typedef struct {
    logic [15:0] instr;
    logic        zf;
    logic [15:0] acc;
    logic [15:0] rdata;
    int          waits;
    int          exp_lat;
    int          exp_inc;
    int          exp_load;
    logic [15:0] exp_pc_in;
    int          exp_exec;
    int          exp_lv;
    logic [15:0] exp_lv_data;
    logic        exp_data;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic        exp_halt;
    logic [15:0] exp_next;
  } vec_t;

  vec_t vecs [9];

  int          o_lat, o_inc, o_load, o_exec, o_lv;
  logic [15:0] o_pc_in, o_lv_data, o_addr, o_wdata, o_next;
  logic        o_data, o_we, o_stable, o_halt, o_excl, o_done;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in FETCH; returns at the next
  // fetch or on HALT. The bench plays memory and records what it sees.
  task automatic applyStimulus(input vec_t v);
    int dwait;
    logic adv_seen;
    zero_flag = v.zf;
    acc_in    = v.acc;
    o_lat = 0; o_inc = 0; o_load = 0; o_exec = 0; o_lv = 0;
    o_pc_in = '0; o_lv_data = '0; o_addr = '0; o_wdata = '0; o_next = '0;
    o_data = 1'b0; o_we = 1'b0; o_stable = 1'b1; o_halt = 1'b0; o_excl = 1'b1; o_done = 1'b0;
    dwait = 0;
    adv_seen = 1'b0;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = v.instr;
    for (int k = 2; k <= 40 && !o_done; k++) begin
      @(negedge clk);
      mem_bus.mem_ready = 1'b0;
      mem_bus.mem_rdata = '0;
      if (int'(pc_inc) + int'(pc_load) + int'(pc_rst) > 1) o_excl = 1'b0;
      if (!pc_load && pc_in != '0) o_excl = 1'b0;
      if (pc_inc) begin o_inc++; adv_seen = 1'b1; end
      if (pc_load) begin o_load++; o_pc_in = pc_in; adv_seen = 1'b1; end
      if (exec_strobe) o_exec++;
      if (load_valid) begin o_lv++; o_lv_data = load_data; end
      if (halted) begin
        o_halt = 1'b1; o_lat = k - 1; o_done = 1'b1;
      end else if (mem_bus.mem_req && adv_seen) begin
        o_lat = k - 1; o_next = mem_bus.mem_addr; o_done = 1'b1;
      end else if (mem_bus.mem_req) begin
        if (!o_data) begin
          o_data = 1'b1; o_we = mem_bus.mem_we; o_addr = mem_bus.mem_addr; o_wdata = mem_bus.mem_wdata;
        end else if (o_we !== mem_bus.mem_we || o_addr !== mem_bus.mem_addr || o_wdata !== mem_bus.mem_wdata) begin
          o_stable = 1'b0;
        end
        dwait++;
        if (dwait > v.waits) begin
          mem_bus.mem_ready = 1'b1;
          mem_bus.mem_rdata = v.rdata;
        end
      end
    end
  endtask

  initial begin
    int   n;
    logic bad;
    logic inc_seen;

    vecs[0] = '{16'h0000, 1'b0, 16'h0000, 16'h0000, 0, 3, 1, 0, 16'h0000, 0, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001};
    vecs[1] = '{16'h1123, 1'b0, 16'h0000, 16'hBEEF, 2, 6, 1, 0, 16'h0000, 0, 1, 16'hBEEF, 1'b1, 1'b0, 16'h0123, 16'h0000, 1'b0, 16'h0002};
    vecs[2] = '{16'h2040, 1'b0, 16'h55AA, 16'h0000, 1, 5, 1, 0, 16'h0000, 0, 0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h55AA, 1'b0, 16'h0003};
    vecs[3] = '{16'h3ABC, 1'b0, 16'h0000, 16'h0000, 0, 3, 0, 1, 16'h0ABC, 0, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0ABC};
    vecs[4] = '{16'h4010, 1'b0, 16'h0000, 16'h0000, 0, 3, 1, 0, 16'h0000, 0, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0ABD};
    vecs[5] = '{16'h4010, 1'b1, 16'h0000, 16'h0000, 0, 3, 0, 1, 16'h0010, 0, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0010};
    vecs[6] = '{16'h5007, 1'b1, 16'h1234, 16'h0000, 0, 4, 1, 0, 16'h0000, 1, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0011};
    vecs[7] = '{16'hE000, 1'b0, 16'h0000, 16'h0000, 0, 4, 1, 0, 16'h0000, 1, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0012};
    vecs[8] = '{16'hF000, 1'b0, 16'h0000, 16'h0000, 0, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000};

    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pc_rst", pc_rst, 1);
    checkOutput("rst_pc_ctl", {pc_inc, pc_load}, 0);
    checkOutput("rst_mem_req", mem_bus.mem_req, 0);
    checkOutput("rst_flags", {halted, fault, load_valid, exec_strobe}, 0);
    checkOutput("rst_ir", ir, 0);
    checkOutput("rst_load_data", load_data, 0);
    reset = 1'b1;
    #1;
    checkOutput("pcrst_cycle", pc_rst, 1);
    @(negedge clk);
    checkOutput("first_fetch_req", {mem_bus.mem_req, mem_bus.mem_we}, 2'b10);
    checkOutput("first_fetch_addr", mem_bus.mem_addr, 16'h0000);
    checkOutput("first_fetch_pc_rst", pc_rst, 0);

    // Single-instruction vectors
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_latency", i), o_lat, vecs[i].exp_lat);
      checkOutput($sformatf("v%0d_pc_inc", i), o_inc, vecs[i].exp_inc);
      checkOutput($sformatf("v%0d_pc_load", i), o_load, vecs[i].exp_load);
      checkOutput($sformatf("v%0d_pc_in", i), o_pc_in, vecs[i].exp_pc_in);
      checkOutput($sformatf("v%0d_exec", i), o_exec, vecs[i].exp_exec);
      checkOutput($sformatf("v%0d_load_valid", i), o_lv, vecs[i].exp_lv);
      if (vecs[i].exp_lv != 0) checkOutput($sformatf("v%0d_load_data", i), o_lv_data, vecs[i].exp_lv_data);
      checkOutput($sformatf("v%0d_data_access", i), o_data, vecs[i].exp_data);
      if (vecs[i].exp_data) begin
        checkOutput($sformatf("v%0d_mem_we", i), o_we, vecs[i].exp_we);
        checkOutput($sformatf("v%0d_mem_addr", i), o_addr, vecs[i].exp_addr);
        checkOutput($sformatf("v%0d_mem_wdata", i), o_wdata, vecs[i].exp_wdata);
        checkOutput($sformatf("v%0d_bus_stable", i), o_stable, 1);
      end
      checkOutput($sformatf("v%0d_halted", i), o_halt, vecs[i].exp_halt);
      if (!vecs[i].exp_halt) checkOutput($sformatf("v%0d_next_addr", i), o_next, vecs[i].exp_next);
      checkOutput($sformatf("v%0d_pc_ctl_excl", i), o_excl, 1);
      checkOutput($sformatf("v%0d_ir", i), ir, vecs[i].instr);
    end

    // Halted: stays put without touching memory until start
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (!halted || mem_bus.mem_req || pc_inc || pc_load) bad = 1'b1;
    end
    checkOutput("halt_hold", bad, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("resume_pc_inc", {pc_inc, halted}, 2'b10);
    @(negedge clk);
    checkOutput("resume_fetch", {mem_bus.mem_req, mem_bus.mem_we}, 2'b10);
    checkOutput("resume_fetch_addr", mem_bus.mem_addr, 16'h0013);

    // Fetch stalls until the timeout trips
    n = 0;
    for (int c = 0; c < 30 && mem_bus.mem_req; c++) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout_req_cycles", n, TIMEOUT);
    checkOutput("timeout_halted_fault", {halted, fault, mem_bus.mem_req}, 3'b110);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    inc_seen = pc_inc;
    @(negedge clk);
    inc_seen = inc_seen | pc_inc;
    checkOutput("fault_start_ignored", {halted, fault, inc_seen}, 3'b110);

    // Only reset clears the sticky fault
    #1 reset = 1'b0;
    #1;
    checkOutput("reset_clears_fault", {fault, pc_rst}, 2'b01);
    checkOutput("reset_clears_ir", ir, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Ready in the limit cycle completes the fetch
    bad = 1'b0;
    for (int c = 0; c < TIMEOUT - 1; c++) begin
      if (!mem_bus.mem_req) bad = 1'b1;
      @(negedge clk);
    end
    checkOutput("limit_still_fetching", {bad, mem_bus.mem_req}, 2'b01);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 16'h5001;
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = '0;
    checkOutput("limit_ready_wins", {fault, halted, mem_bus.mem_req}, 3'b000);
    checkOutput("limit_ir", ir, 16'h5001);
    @(negedge clk);
    checkOutput("limit_exec", exec_strobe, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("refetch_addr", {mem_bus.mem_req, mem_bus.mem_addr}, {1'b1, 16'h0001});

    // Asynchronous reset in the middle of a stalled fetch
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_mem_req", {mem_bus.mem_req, pc_rst}, 2'b01);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
